// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures one retire record per retiring instruction into a FIFO and drains it to the
//   trace/log sink over a valid/ready port. Counts cycles, retired instructions and dropped
//   records, and raises done once a halt has been captured and the FIFO has drained.
//
//   Build option: define TRACE_FILTER_EN to skip records for retires that write neither a
//   register nor memory and are not HALT (branches/NOPs). They are still counted in inst_cnt.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ret_*                 commit-point probes (valid, pc, regwr/wreg/wdata, memrd/memwr,
//                         addr/mdata, halt)
//   tr_valid/tr_ready     drain handshake; tr_data is the FIFO head (87-bit record)
//   cycle_cnt             cycles since reset, frozen once done
//   inst_cnt              retired instructions (wrapping)
//   drop_cnt              records lost to a full FIFO (saturating)
//   overflow              sticky, set on the first drop
//   done                  halt captured and FIFO drained
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ret_valid,
  input  logic [15:0] ret_pc,
  input  logic        ret_regwr,
  input  logic [2:0]  ret_wreg,
  input  logic [15:0] ret_wdata,
  input  logic        ret_memrd,
  input  logic        ret_memwr,
  input  logic [15:0] ret_addr,
  input  logic [15:0] ret_mdata,
  input  logic        ret_halt,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [86:0] tr_data,
  output logic [31:0] cycle_cnt,
  output logic [15:0] inst_cnt,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned RecW     = 87;
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StRun, StHalted, StDone} state_e;

  state_e          state_q, state_d;
  logic [RecW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic [15:0]     inst_cnt_q, inst_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;

  logic            keep, push_req, full, not_empty, pop, push, drop;
  logic [RecW-1:0] rec;

  always_comb begin
`ifdef TRACE_FILTER_EN
    keep = ret_regwr | ret_memwr | ret_halt;
`else
    keep = 1'b1;
`endif
    not_empty = (count_q != '0);
    full      = (count_q == DepthCnt);
    pop       = not_empty & tr_ready;
    push_req  = (state_q == StRun) & ret_valid & keep;
    // A pop in the same cycle frees the slot for the incoming record.
    push      = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    rec       = {inst_cnt_q, ret_pc, ret_regwr, ret_wreg, ret_wdata, ret_memrd, ret_memwr,
                 ret_addr, ret_mdata, ret_halt};
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Next state and counters.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q | drop;

    if (state_q != StDone) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if ((state_q == StRun) && ret_valid) begin
      inst_cnt_d = inst_cnt_q + 16'd1;
    end
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    unique case (state_q)
      StRun: begin
        // The halt record may itself be dropped; the halt still takes effect.
        if (ret_valid && ret_halt) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        // Look at next occupancy so done rises the cycle after the last pop.
        if (count_d == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; tr_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rec;
    end
  end

  assign tr_valid  = not_empty;
  assign tr_data   = not_empty ? mem_q[rd_ptr_q] : '0;
  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ret_valid = 1'b0;
  logic [15:0] ret_pc = '0;
  logic        ret_regwr = 1'b0;
  logic [2:0]  ret_wreg = '0;
  logic [15:0] ret_wdata = '0;
  logic        ret_memrd = 1'b0;
  logic        ret_memwr = 1'b0;
  logic [15:0] ret_addr = '0;
  logic [15:0] ret_mdata = '0;
  logic        ret_halt = 1'b0;
  logic        tr_valid;
  logic        tr_ready = 1'b0;
  logic [86:0] tr_data;
  logic [31:0] cycle_cnt;
  logic [15:0] inst_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        done;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .ret_valid (ret_valid),
    .ret_pc    (ret_pc),
    .ret_regwr (ret_regwr),
    .ret_wreg  (ret_wreg),
    .ret_wdata (ret_wdata),
    .ret_memrd (ret_memrd),
    .ret_memwr (ret_memwr),
    .ret_addr  (ret_addr),
    .ret_mdata (ret_mdata),
    .ret_halt  (ret_halt),
    .tr_valid  (tr_valid),
    .tr_ready  (tr_ready),
    .tr_data   (tr_data),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [86:0] act, input logic [86:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: record queue plus counters, 0=run 1=halted 2=done.
  logic [86:0] mq[$];
  int          m_state = 0;
  logic [31:0] m_cycle = '0;
  logic [15:0] m_inst  = '0;
  logic [15:0] m_drop  = '0;
  logic        m_ovf   = 1'b0;

  function automatic logic traced(input logic rw, input logic mw, input logic h);
`ifdef TRACE_FILTER_EN
    return rw | mw | h;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin : model
    int old_state;
    if (rst) begin
      mq.delete();
      m_state = 0;
      m_cycle = '0;
      m_inst  = '0;
      m_drop  = '0;
      m_ovf   = 1'b0;
    end else begin
      old_state = m_state;
      if (mq.size() != 0 && tr_ready) void'(mq.pop_front());
      if (m_state == 0 && ret_valid) begin
        if (traced(ret_regwr, ret_memwr, ret_halt)) begin
          if (mq.size() < DEPTH) begin
            mq.push_back({m_inst, ret_pc, ret_regwr, ret_wreg, ret_wdata, ret_memrd, ret_memwr,
                          ret_addr, ret_mdata, ret_halt});
          end else begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_ovf = 1'b1;
          end
        end
        m_inst = m_inst + 16'd1;
        if (ret_halt) m_state = 1;
      end else if (m_state == 1 && mq.size() == 0) begin
        m_state = 2;
      end
      if (old_state != 2) m_cycle = m_cycle + 32'd1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tr_valid", tr_valid, 0);
      chk("rst_tr_data", tr_data, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_inst_cnt", inst_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_done", done, 0);
    end else begin
      chk("tr_valid", tr_valid, (mq.size() != 0));
      chk("tr_data", tr_data, (mq.size() != 0) ? mq[0] : 87'd0);
      chk("cycle_cnt", cycle_cnt, m_cycle);
      chk("inst_cnt", inst_cnt, m_inst);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
      chk("done", done, (m_state == 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ret_valid = 1'b0;
    ret_halt  = 1'b0;
  endtask

  task automatic retire(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                        input logic [15:0] wd, input logic mr, input logic mw,
                        input logic [15:0] a, input logic [15:0] md, input logic h);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_regwr = rw;
    ret_wreg  = wr;
    ret_wdata = wd;
    ret_memrd = mr;
    ret_memwr = mw;
    ret_addr  = a;
    ret_mdata = md;
    ret_halt  = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] last_inum;
    int          popped;
    int          ready_pct;

    // Reset state and three simple retires.
    do_reset();
    chk("t0_tr_valid", tr_valid, 0);
    chk("t0_cycle_cnt", cycle_cnt, 0);
    chk("t0_inst_cnt", inst_cnt, 0);
    chk("t0_done", done, 0);
    tr_ready = 1'b1;
    retire(16'h0000, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    chk("t1_rec0", tr_data, {16'd0, 16'h0000, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0,
                             1'b0});
    retire(16'h0002, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    chk("t1_rec1", tr_data, {16'd1, 16'h0002, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0,
                             1'b0});
    retire(16'h0004, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    chk("t1_rec2", tr_data, {16'd2, 16'h0004, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0,
                             1'b0});
    idle();
    tick();
    chk("t1_inst_cnt", inst_cnt, 3);
    chk("t1_drained", tr_valid, 0);

    // Ten retires into a stalled sink.
    do_reset();
    tr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      retire(16'(i * 2), 1'b1, 3'(i), 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    chk("t2_drop_cnt", drop_cnt, 2);
    chk("t2_overflow", overflow, 1);
    chk("t2_inst_cnt", inst_cnt, 10);
    chk("t2_head_inum", tr_data[86:71], 0);

    // Full FIFO: retire with a same-cycle pop keeps the record.
    retire(16'h0100, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'h1234, 1'b0);
    tr_ready = 1'b1;
    tick();
    idle();
    tr_ready = 1'b0;
    chk("t3_drop_cnt", drop_cnt, 2);
    chk("t3_inst_cnt", inst_cnt, 11);
    chk("t3_head_inum", tr_data[86:71], 1);
    tr_ready  = 1'b1;
    popped    = 0;
    last_inum = '0;
    for (int k = 0; k < 20; k++) begin
      if (!tr_valid) break;
      last_inum = tr_data[86:71];
      popped++;
      tick();
    end
    chk("t3_popped", 87'(popped), 8);
    chk("t3_last_inum", last_inum, 10);

    // Halt, then further retires that must be ignored.
    retire(16'h0010, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    chk("t4_halt_bit", tr_data[0], 1);
    chk("t4_halt_pc", tr_data[70:55], 16'h0010);
    chk("t4_not_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      retire(16'h0012 + 16'(2 * i), 1'b1, 3'd2, 16'h7, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      if (i == 0) chk("t4_done_after_pop", done, 1);
    end
    idle();
    chk("t4_inst_cnt", inst_cnt, 12);
    chk("t4_done_hold", done, 1);

    // Reset mid-drain with 5 entries held.
    do_reset();
    tr_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      retire(16'(i), 1'b1, 3'd3, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    tr_ready = 1'b1;
    tick();
    tick();
    tick();
    tr_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_tr_valid", tr_valid, 0);
    chk("t5_inst_cnt", inst_cnt, 0);
    chk("t5_drop_cnt", drop_cnt, 0);
    chk("t5_cycle_cnt", cycle_cnt, 0);
    chk("t5_overflow", overflow, 0);
    rst = 1'b0;

`ifdef TRACE_FILTER_EN
    do_reset();
    tr_ready = 1'b0;
    retire(16'h0020, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    retire(16'h0022, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b0);
    tick();
    idle();
    tick();
    chk("t6_inst_cnt", inst_cnt, 2);
    chk("t6_inum", tr_data[86:71], 1);
    chk("t6_mdata", tr_data[16:1], 16'hBEEF);
    tr_ready = 1'b1;
    tick();
    chk("t6_single", tr_valid, 0);
`endif

    // Randomized traffic with varying sink pressure, halts and resets.
    do_reset();
    ready_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) ready_pct = $urandom_range(10, 95);
      if ((done && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        retire(16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom),
               1'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 99) == 0));
        ret_valid = ($urandom_range(0, 3) != 0);
        tr_ready  = ($urandom_range(1, 100) <= ready_pct);
        tick();
      end
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
